// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
package apb_pkg;

  localparam int          APB_ADDR_W = 32;
  localparam int          APB_DATA_W = 32;
  localparam logic [31:0] APB_BASE   = 32'h7000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - first-word-fall-through command FIFO, DEPTH a power of two
module apb_cmd_fifo import apb_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = apb_cmd_t
) (
  input  logic   pclk,
  input  logic   preset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the empty flag guards every read.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB3 requester: queued commands, SETUP/ACCESS transfers,
// wait-state timeout and a held response port
module apb_master_ctrl import apb_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e        state_q, state_d;
  cmd_t              push_cmd, head_cmd;
  logic              fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .pclk      (pclk),
    .preset    (preset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  // The counter holds the number of wait cycles already spent before this one.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          paddr_d  = head_cmd.addr;
          pwrite_d = head_cmd.write;
          pwdata_d = head_cmd.wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = pwrite ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pwrite_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            pwrite_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed bench for apb_master_ctrl with a behavioural APB slave
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        busy, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int          checks = 0;
  int          failures = 0;
  int          wait_cfg = 0;
  logic        stuck = 1'b0;
  logic        err_cfg = 1'b0;
  int          wait_cnt;
  logic [31:0] mem [16];

  always #5 pclk = ~pclk;

  apb_master_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // Slave: wait_cfg wait states per access, stuck holds pready low, err_cfg drives pslverr.
  assign pready  = !stuck && (wait_cnt >= wait_cfg);
  assign pslverr = err_cfg;
  assign prdata  = mem[paddr[5:2]];

  always @(posedge pclk) begin
    if (preset) begin
      wait_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + i;
    end else begin
      wait_cnt <= (psel && penable && !pready) ? wait_cnt + 1 : 0;
      if (psel && penable && pready && pwrite && !pslverr) mem[paddr[5:2]] <= pwdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // -1: pready stuck low
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;    // edges from push to rsp_valid
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] q_addr [5];
  logic [31:0] q_wdata [5];
  logic        q_write [5];
  logic [31:0] q_exp [4];

  initial begin
    int lat, npsel, npen, nbad, nr, last;
    logic [31:0] held_rdata;

    vecs[0] = '{1'b1, APB_BASE + 32'h00, 32'd6,         0, 1'b0, 32'h0,         1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, APB_BASE + 32'h00, 32'h0,         0, 1'b0, 32'd6,         1'b0, 1'b0, 3};
    vecs[2] = '{1'b1, APB_BASE + 32'h10, 32'hDEADBEEF,  3, 1'b0, 32'h0,         1'b0, 1'b0, 6};
    vecs[3] = '{1'b0, APB_BASE + 32'h10, 32'h0,         2, 1'b0, 32'hDEADBEEF,  1'b0, 1'b0, 5};
    vecs[4] = '{1'b0, APB_BASE + 32'h20, 32'h0,        -1, 1'b0, 32'h0,         1'b1, 1'b1, 18};
    vecs[5] = '{1'b0, APB_BASE + 32'h04, 32'h0,         0, 1'b0, 32'hA5A50001,  1'b0, 1'b0, 3};
    vecs[6] = '{1'b1, APB_BASE + 32'h14, 32'h1,         0, 1'b1, 32'h0,         1'b1, 1'b0, 3};
    vecs[7] = '{1'b0, APB_BASE + 32'h10, 32'h0,         0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 3};

    q_write = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    q_addr  = '{APB_BASE + 32'h04, APB_BASE + 32'h08, APB_BASE + 32'h0C, APB_BASE + 32'h0C, APB_BASE};
    q_wdata = '{32'h0B1407E9, 32'h61706861, 32'h676C7573, 32'h0, 32'h00000BAD};
    q_exp   = '{32'h0, 32'h0, 32'h0, 32'h676C7573};

    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    check("rst_psel",    32'(psel),        0);
    check("rst_penable", 32'(penable),     0);
    check("rst_pwrite",  32'(pwrite),      0);
    check("rst_paddr",   paddr,            0);
    check("rst_pwdata",  pwdata,           0);
    check("rst_rsp",     32'({rsp_valid, rsp_err, rsp_timeout}), 0);
    check("rst_rdata",   rsp_rdata,        0);
    check("rst_ready",   32'(cmd_ready),   1);
    check("rst_busy",    32'(busy),        0);
    preset = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      stuck     = (vecs[v].waits < 0);
      wait_cfg  = stuck ? 0 : vecs[v].waits;
      err_cfg   = vecs[v].err;
      cmd_write = vecs[v].write;
      cmd_addr  = vecs[v].addr;
      cmd_wdata = vecs[v].wdata;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      lat = 0; npsel = 0; npen = 0; nbad = 0;
      while (!rsp_valid && lat < 40) begin
        tick();
        lat++;
        if (psel) npsel++;
        if (penable) npen++;
        if (psel && (paddr !== vecs[v].addr || pwrite !== vecs[v].write ||
                     (vecs[v].write && pwdata !== vecs[v].wdata))) nbad++;
      end
      check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 1);
      check($sformatf("v%0d_latency", v),   32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v),     rsp_rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v),       32'(rsp_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_timeout", v),   32'(rsp_timeout), 32'(vecs[v].exp_to));
      check($sformatf("v%0d_psel_cycles", v),    32'(npsel), 32'(vecs[v].exp_lat - 1));
      check($sformatf("v%0d_penable_cycles", v), 32'(npen),  32'(vecs[v].exp_lat - 2));
      check($sformatf("v%0d_addr_stable", v),    32'(nbad),  0);
      stuck = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_released", v), 32'(rsp_valid), 0);
      check($sformatf("v%0d_idle", v),         32'(busy), 0);
    end

    // pslverr response held for 5 cycles while four commands fill the queue
    err_cfg = 1'b1; wait_cfg = 0;
    cmd_write = 1'b1; cmd_addr = APB_BASE + 32'h18; cmd_wdata = 32'h55; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("hold_rsp_valid", 32'(rsp_valid), 1);
    check("hold_err",       32'(rsp_err), 1);
    check("hold_timeout",   32'(rsp_timeout), 0);
    held_rdata = rsp_rdata;
    err_cfg = 1'b0;
    nbad = 0;
    for (int c = 0; c < 5; c++) begin
      cmd_write = q_write[c]; cmd_addr = q_addr[c]; cmd_wdata = q_wdata[c]; cmd_valid = 1'b1;
      tick();
      if (!rsp_valid || !rsp_err || rsp_timeout || rsp_rdata !== held_rdata || psel || penable) nbad++;
      if (c >= 3) check($sformatf("full_cmd_ready_%0d", c), 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    check("hold_stable", 32'(nbad), 0);
    check("hold_rdata",  held_rdata, 0);

    rsp_ready = 1'b1;
    tick();
    nr = 0; last = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rsp_valid) begin
        if (nr < 4) begin
          check($sformatf("q%0d_rdata", nr), rsp_rdata, q_exp[nr]);
          check($sformatf("q%0d_err", nr),   32'(rsp_err), 0);
          if (nr > 0) check($sformatf("q%0d_interval", nr), 32'(c - last), 4);
        end
        nr++;
        last = c;
      end
    end
    rsp_ready = 1'b0;
    check("q_count",   32'(nr), 4);
    check("q_idle",    32'(busy), 0);
    check("q_ready",   32'(cmd_ready), 1);

    // reset asserted in the middle of ACCESS with a second command queued
    wait_cfg = 5;
    cmd_write = 1'b0; cmd_addr = APB_BASE + 32'h04; cmd_valid = 1'b1;
    tick();
    cmd_addr = APB_BASE + 32'h08;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!penable && lat < 10) begin
      tick();
      lat++;
    end
    check("mid_access_reached", 32'(penable), 1);
    #2;
    preset = 1'b1;
    #1;
    check("mid_rst_psel",    32'(psel), 0);
    check("mid_rst_penable", 32'(penable), 0);
    check("mid_rst_busy",    32'(busy), 0);
    check("mid_rst_ready",   32'(cmd_ready), 1);
    tick();
    preset = 1'b0;
    wait_cfg = 0;
    rsp_ready = 1'b1;
    nbad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid || psel) nbad++;
    end
    check("post_rst_quiet", 32'(nbad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
